// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the parametrised 1R1W SRAM model.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int mask_width(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic int depth(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset zero-fill sequencer; owns the array write port and gates user requests while busy.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_wen,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [MASK_WIDTH-1:0] i_wmask,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_wr_accept,
  output logic                  o_rd_accept,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [MASK_WIDTH-1:0] o_mem_mask,
  output logic [DATA_WIDTH-1:0] o_mem_wdata
);

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [ADDR_WIDTH-1:0] w_clr_ptr_nxt;
  logic                  r_busy;

  // State, fill pointer and busy flag; busy is registered alongside the state it mirrors
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= RESET_STATE;
      r_clr_ptr <= {ADDR_WIDTH{1'b0}};
      r_busy    <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_busy    <= (w_state_nxt == CLEAR);
    end
  end

  // Next state and write-port mux: the fill owns the port until the last address is zeroed
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    o_wr_accept   = 1'b0;
    o_rd_accept   = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = i_waddr;
    o_mem_mask    = i_wmask;
    o_mem_wdata   = i_wdata;
    case (r_state)
      CLEAR: begin
        o_mem_we      = 1'b1;
        o_mem_addr    = r_clr_ptr;
        o_mem_mask    = {MASK_WIDTH{1'b1}};
        o_mem_wdata   = {DATA_WIDTH{1'b0}};
        w_clr_ptr_nxt = r_clr_ptr + ADDR_WIDTH'(1);
        if (r_clr_ptr == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = READY;
        end else begin
          w_state_nxt = CLEAR;
        end
      end
      READY: begin
        o_wr_accept = i_wen;
        o_rd_accept = i_ren;
        o_mem_we    = i_wen;
      end
      default: begin
        w_state_nxt   = RESET_STATE;
        w_clr_ptr_nxt = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1-read/1-write SRAM: byte-masked writes, write-first collision forwarding,
// read latency of 1 or 2 cycles, optional zero-fill after reset.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                            clk,
  input  logic                                            nrst,
  input  logic                                            wen,
  input  logic [ADDR_WIDTH-1:0]                           waddr,
  input  logic [mask_width(DATA_WIDTH, BYTE_WIDTH)-1:0]   wmask,
  input  logic [DATA_WIDTH-1:0]                           wdata,
  input  logic                                            ren,
  input  logic [ADDR_WIDTH-1:0]                           raddr,
  output logic [DATA_WIDTH-1:0]                           rdata,
  output logic                                            rvalid,
  output logic                                            busy
);

  localparam int MASK_WIDTH = mask_width(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH      = depth(ADDR_WIDTH);

  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [MASK_WIDTH-1:0] w_mem_mask;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_old_data;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  sram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .MASK_WIDTH     (MASK_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk         (clk),
    .nrst        (nrst),
    .i_wen       (wen),
    .i_ren       (ren),
    .i_waddr     (waddr),
    .i_wmask     (wmask),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_wr_accept (w_wr_accept),
    .o_rd_accept (w_rd_accept),
    .o_mem_we    (w_mem_we),
    .o_mem_addr  (w_mem_addr),
    .o_mem_mask  (w_mem_mask),
    .o_mem_wdata (w_mem_wdata)
  );

  assign w_collide = w_wr_accept & w_rd_accept & (waddr == raddr);

  for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] r_mem [DEPTH];

    // Lane storage; contents survive nrst and are only cleared by the fill sequencer
    always_ff @(posedge clk) begin
      if (w_mem_we && w_mem_mask[gi]) begin
        r_mem[w_mem_addr] <= w_mem_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign w_old_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = r_mem[raddr];
    assign w_fwd_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = (w_collide && wmask[gi]) ?
                                                     wdata[gi*BYTE_WIDTH +: BYTE_WIDTH] :
                                                     w_old_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    // First read stage captures the word at the sample edge so later writes cannot disturb it
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_s1_data  <= {DATA_WIDTH{1'b0}};
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_data  <= w_fwd_data;
        r_s1_valid <= w_rd_accept;
      end
    end

    assign w_out_data  = r_s1_data;
    assign w_out_valid = r_s1_valid;
  end else begin : g_lat1
    assign w_out_data  = w_fwd_data;
    assign w_out_valid = w_rd_accept;
  end

  // Output stage: rvalid pulses per result, rdata holds between results
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rdata  <= {DATA_WIDTH{1'b0}};
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_out_valid;
      if (w_out_valid) begin
        r_rdata <= w_out_data;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Scoreboard bench: two SRAM instances (latency 1 and 2) share stimulus and a word-level model.
module tb_sram_1r1w_param;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [3:0]    wmask;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2, busy1, busy2;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            clr_left = 0;
  bit            mon_en   = 1'b0;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last1, last2;
  exp_t          q1[$], q2[$];
  exp_t          em1, em2;

  sram_1r1w_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                    .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .wen(wen), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

  sram_1r1w_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                    .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .nrst(nrst), .wen(wen), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 monitor: every rvalid must match the oldest expected read, on its due cycle
  always @(negedge clk) begin
    if (mon_en && nrst) begin
      n_checks++;
      if (rvalid1) begin
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL lat1_spurious_rvalid: got rdata=%h with no read outstanding", rdata1);
        end else begin
          em1   = q1.pop_front();
          last1 = em1.data;
          if (rdata1 !== em1.data || cyc != em1.due) begin
            n_fail++;
            $display("FAIL lat1_read: got %h at cyc %0d, want %h at cyc %0d",
                     rdata1, cyc, em1.data, em1.due);
          end
        end
      end else if (rdata1 !== last1) begin
        n_fail++;
        $display("FAIL lat1_hold: got %h, want %h", rdata1, last1);
      end
    end
  end

  // Latency-2 monitor
  always @(negedge clk) begin
    if (mon_en && nrst) begin
      n_checks++;
      if (rvalid2) begin
        if (q2.size() == 0) begin
          n_fail++;
          $display("FAIL lat2_spurious_rvalid: got rdata=%h with no read outstanding", rdata2);
        end else begin
          em2   = q2.pop_front();
          last2 = em2.data;
          if (rdata2 !== em2.data || cyc != em2.due) begin
            n_fail++;
            $display("FAIL lat2_read: got %h at cyc %0d, want %h at cyc %0d",
                     rdata2, cyc, em2.data, em2.due);
          end
        end
      end else if (rdata2 !== last2) begin
        n_fail++;
        $display("FAIL lat2_hold: got %h, want %h", rdata2, last2);
      end
    end
  end

  // Called just after a posedge; drives one request cycle and advances the model by one edge.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [3:0] wm,
                       input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    exp_t          e;
    logic [DW-1:0] word;
    wen = w; waddr = wa; wmask = wm; wdata = wd; ren = r; raddr = ra;
    n_checks++;
    if (busy1 !== (clr_left > 0) || busy2 !== (clr_left > 0)) begin
      n_fail++;
      $display("FAIL busy: got %b/%b, want %b", busy1, busy2, clr_left > 0);
    end
    if (clr_left == 0) begin
      if (r) begin
        word = mdl[ra];
        if (w && wa == ra) begin
          for (int i = 0; i < 4; i++) if (wm[i]) word[i*8 +: 8] = wd[i*8 +: 8];
        end
        e.data = word;
        e.due  = cyc + 1; q1.push_back(e);
        e.due  = cyc + 2; q2.push_back(e);
      end
      if (w) begin
        for (int i = 0; i < 4; i++) if (wm[i]) mdl[wa][i*8 +: 8] = wd[i*8 +: 8];
      end
    end else begin
      clr_left--;
      if (clr_left == 0) begin
        for (int a = 0; a < DEPTH; a++) mdl[a] = 32'h0000_0000;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic do_reset(input int hold);
    nrst = 1'b0; wen = 1'b0; ren = 1'b0;
    q1.delete(); q2.delete();
    last1 = 32'h0; last2 = 32'h0;
    repeat (hold) @(posedge clk);
    #1;
    n_checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0 ||
        rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b/%b rvalid=%b/%b rdata=%h/%h, want 1/1 0/0 0/0",
               busy1, busy2, rvalid1, rvalid2, rdata1, rdata2);
    end
    nrst     = 1'b1;
    clr_left = DEPTH;
  endtask

  initial begin
    nrst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = 4'h0; raddr = 4'h0; wmask = 4'h0; wdata = 32'h0;
    @(posedge clk); #1;
    do_reset(3);
    mon_en = 1'b1;

    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, AW'(a));

    cycle(1'b1, 4'd10, 4'hF, 32'h5A5A_1234, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd10);

    cycle(1'b1, 4'd5, 4'hF, 32'hAABB_CCDD, 1'b0, 4'h0);
    cycle(1'b1, 4'd5, 4'b0101, 32'h1122_3344, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);

    cycle(1'b1, 4'd3, 4'b1100, 32'hDEAD_BEEF, 1'b1, 4'd3);
    idle(3);

    for (int a = 0; a < 4; a++) cycle(1'b1, AW'(a), 4'hF, 32'h10 + a, 1'b0, 4'h0);
    for (int a = 0; a < 4; a++) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, AW'(a));
    idle(4);

    do_reset(2);
    repeat (7) cycle(1'b1, 4'd1, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd1);
    do_reset(2);
    repeat (DEPTH) cycle(1'b1, 4'd1, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd1);
    cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd10);
    cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1);
    idle(3);

    repeat (400) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      cycle(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), ra);
    end
    idle(4);

    n_checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d reads still outstanding, want 0/0", q1.size(), q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
